// File: rtl/core_config_pkg.sv
// Core-wide configuration constants shared by the execution and write-back stages.
//   XLEN       : architectural data width
//   REG_ADDR_W : register-file index width
package core_config_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;

endpackage : core_config_pkg

// File: rtl/commit_unit.sv
// commit_unit: write-back stage, receiver side of the execution-unit commit path.
// Collects finished results from N_UNITS execution units, grants one commit per
// cycle in round-robin order, drives the register-file write port and returns a
// one-cycle one-hot clear to the granted unit.
//
// Ports
//   clk, rst_n         : core clock, asynchronous active-low reset
//   u_valid/u_res/u_rd : per-unit result valid, data and destination register
//   u_error            : per-unit result is erroneous (no write, error pulse)
//   u_clear            : one-hot pulse, unit result consumed (all ones on flush)
//   hold               : freeze commits while high
//   flush              : discard all pending results (wins over hold)
//   rf_we/rf_waddr/rf_wdata : register-file write port (addr/data hold when idle)
//   err_valid/err_unit : one-cycle pulse and source unit of an erroneous commit
//   err_count          : saturating error-commit counter, present only when
//                        COMMIT_ERR_CNT_EN is defined
module commit_unit #(
    parameter int unsigned N_UNITS    = 4,
    parameter int unsigned XLEN       = core_config_pkg::XLEN,
    parameter int unsigned REG_ADDR_W = core_config_pkg::REG_ADDR_W
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [N_UNITS-1:0]                   u_valid,
    input  logic [N_UNITS-1:0][XLEN-1:0]         u_res,
    input  logic [N_UNITS-1:0][REG_ADDR_W-1:0]   u_rd,
    input  logic [N_UNITS-1:0]                   u_error,
    output logic [N_UNITS-1:0]                   u_clear,
    input  logic                                 hold,
    input  logic                                 flush,
    output logic                                 rf_we,
    output logic [REG_ADDR_W-1:0]                rf_waddr,
    output logic [XLEN-1:0]                      rf_wdata,
    output logic                                 err_valid,
    output logic [$clog2(N_UNITS)-1:0]           err_unit
`ifdef COMMIT_ERR_CNT_EN
    ,
    output logic [15:0]                          err_count
`endif
);

    localparam int unsigned IDX_W = $clog2(N_UNITS);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HELD  = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;

    logic [N_UNITS-1:0]     elig;
    logic                   gnt_found;
    logic [IDX_W-1:0]       gnt_idx;
    logic [31:0]            cand;
    logic                   grant_en;

    logic [N_UNITS-1:0]     clear_d;
    logic                   we_d;
    logic [REG_ADDR_W-1:0]  waddr_d;
    logic [XLEN-1:0]        wdata_d;
    logic                   errv_d;
    logic [IDX_W-1:0]       erru_d;

    // A unit whose clear is on the wire this cycle still shows valid; mask it.
    assign elig = u_valid & ~u_clear;

    // Round-robin pick: first eligible unit at or above ptr, wrapping.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int unsigned k = 0; k < N_UNITS; k++) begin
            cand = 32'(ptr_q) + 32'(k);
            if (cand >= 32'(N_UNITS)) begin
                cand = cand - 32'(N_UNITS);
            end
            if (!gnt_found && elig[IDX_W'(cand)]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDX_W'(cand);
            end
        end
    end

    // Next state and next registered outputs.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        clear_d  = '0;
        we_d     = 1'b0;
        waddr_d  = rf_waddr;
        wdata_d  = rf_wdata;
        errv_d   = 1'b0;
        erru_d   = err_unit;
        // During the flush cycle every clear is up, so nothing could be granted anyway.
        grant_en = (state_q != ST_FLUSH) && !hold && !flush;

        if (flush) begin
            state_d = ST_FLUSH;
        end else if (hold) begin
            state_d = ST_HELD;
        end else begin
            state_d = ST_RUN;
        end

        if (flush) begin
            clear_d = '1;
            ptr_d   = '0;
        end else if (grant_en && gnt_found) begin
            clear_d[gnt_idx] = 1'b1;
            ptr_d = (gnt_idx == IDX_W'(N_UNITS - 1)) ? '0 : gnt_idx + IDX_W'(1);
            if (u_error[gnt_idx]) begin
                errv_d = 1'b1;
                erru_d = gnt_idx;
            end else if (u_rd[gnt_idx] != '0) begin
                we_d    = 1'b1;
                waddr_d = u_rd[gnt_idx];
                wdata_d = u_res[gnt_idx];
            end
        end
    end

    // State, pointer and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            ptr_q     <= '0;
            u_clear   <= '0;
            rf_we     <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
            err_valid <= 1'b0;
            err_unit  <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            u_clear   <= clear_d;
            rf_we     <= we_d;
            rf_waddr  <= waddr_d;
            rf_wdata  <= wdata_d;
            err_valid <= errv_d;
            err_unit  <= erru_d;
        end
    end

`ifdef COMMIT_ERR_CNT_EN
    // Saturating count of error pulses; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (err_valid && (err_count != 16'hFFFF)) begin
            err_count <= err_count + 16'd1;
        end
    end
`endif

endmodule : commit_unit

// File: tb/tb_commit_unit.sv
// Testbench for commit_unit (N_UNITS=4, XLEN=32, REG_ADDR_W=5).
// Table of per-cycle vectors with hand-derived expected outputs, queued when
// driven and compared one cycle later; plus reset-mid-commit and, when
// COMMIT_ERR_CNT_EN is defined, error-counter saturation.
module tb_commit_unit;

    localparam int unsigned N  = 4;
    localparam int unsigned XW = 32;
    localparam int unsigned AW = 5;

    localparam logic [XW-1:0] R0 = 32'h0000_0011;
    localparam logic [XW-1:0] R1 = 32'h0000_00AA;
    localparam logic [XW-1:0] R2 = 32'h1234_5678;
    localparam logic [XW-1:0] R3 = 32'hDEAD_BEEF;

    logic                      clk;
    logic                      rst_n;
    logic [N-1:0]              u_valid;
    logic [N-1:0][XW-1:0]      u_res;
    logic [N-1:0][AW-1:0]      u_rd;
    logic [N-1:0]              u_error;
    logic [N-1:0]              u_clear;
    logic                      hold;
    logic                      flush;
    logic                      rf_we;
    logic [AW-1:0]             rf_waddr;
    logic [XW-1:0]             rf_wdata;
    logic                      err_valid;
    logic [1:0]                err_unit;
`ifdef COMMIT_ERR_CNT_EN
    logic [15:0]               err_count;
`endif

    commit_unit #(.N_UNITS(N), .XLEN(XW), .REG_ADDR_W(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .u_valid   (u_valid),
        .u_res     (u_res),
        .u_rd      (u_rd),
        .u_error   (u_error),
        .u_clear   (u_clear),
        .hold      (hold),
        .flush     (flush),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .err_valid (err_valid),
        .err_unit  (err_unit)
`ifdef COMMIT_ERR_CNT_EN
        ,
        .err_count (err_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  err;
        logic [4:0]  rd0;
        logic        hold;
        logic        flush;
        logic [3:0]  e_clear;
        logic        e_we;
        logic [4:0]  e_waddr;
        logic [31:0] e_wdata;
        logic        e_errv;
        logic [1:0]  e_erru;
    } vec_t;

    typedef struct {
        int          idx;
        logic [3:0]  clear;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        errv;
        logic [1:0]  erru;
    } exp_t;

    localparam int NV = 27;
    vec_t vecs [NV];
    exp_t sb [$];

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_pop();
        exp_t e;
        e = sb.pop_front();
        chk($sformatf("v%0d u_clear", e.idx),   32'(u_clear),   32'(e.clear));
        chk($sformatf("v%0d rf_we", e.idx),     32'(rf_we),     32'(e.we));
        chk($sformatf("v%0d rf_waddr", e.idx),  32'(rf_waddr),  32'(e.waddr));
        chk($sformatf("v%0d rf_wdata", e.idx),  rf_wdata,       e.wdata);
        chk($sformatf("v%0d err_valid", e.idx), 32'(err_valid), 32'(e.errv));
        chk($sformatf("v%0d err_unit", e.idx),  32'(err_unit),  32'(e.erru));
    endtask

    task automatic check_outs(input string tag, input logic [3:0] c, input logic we,
                              input logic [4:0] wa, input logic [31:0] wd,
                              input logic ev, input logic [1:0] eu);
        chk({tag, " u_clear"},   32'(u_clear),   32'(c));
        chk({tag, " rf_we"},     32'(rf_we),     32'(we));
        chk({tag, " rf_waddr"},  32'(rf_waddr),  32'(wa));
        chk({tag, " rf_wdata"},  rf_wdata,       wd);
        chk({tag, " err_valid"}, 32'(err_valid), 32'(ev));
        chk({tag, " err_unit"},  32'(err_unit),  32'(eu));
    endtask

    initial begin
        // valid, err, rd0, hold, flush | clear, we, waddr, wdata, errv, erru
        vecs[0]  = '{4'b0010, 4'b0000, 5'd3, 1'b0, 1'b0, 4'b0010, 1'b1, 5'd5, R1, 1'b0, 2'd0};
        vecs[1]  = '{4'b0010, 4'b0000, 5'd3, 1'b0, 1'b0, 4'b0000, 1'b0, 5'd5, R1, 1'b0, 2'd0};
        vecs[2]  = '{4'b0000, 4'b0000, 5'd3, 1'b0, 1'b0, 4'b0000, 1'b0, 5'd5, R1, 1'b0, 2'd0};
        vecs[3]  = '{4'b0000, 4'b0000, 5'd3, 1'b0, 1'b1, 4'b1111, 1'b0, 5'd5, R1, 1'b0, 2'd0};
        vecs[4]  = '{4'b1111, 4'b0000, 5'd3, 1'b0, 1'b0, 4'b0000, 1'b0, 5'd5, R1, 1'b0, 2'd0};
        vecs[5]  = '{4'b1111, 4'b0000, 5'd3, 1'b0, 1'b0, 4'b0001, 1'b1, 5'd3, R0, 1'b0, 2'd0};
        vecs[6]  = '{4'b1110, 4'b0000, 5'd3, 1'b0, 1'b0, 4'b0010, 1'b1, 5'd5, R1, 1'b0, 2'd0};
        vecs[7]  = '{4'b1100, 4'b0000, 5'd3, 1'b0, 1'b0, 4'b0100, 1'b1, 5'd9, R2, 1'b0, 2'd0};
        vecs[8]  = '{4'b1000, 4'b0000, 5'd3, 1'b0, 1'b0, 4'b1000, 1'b1, 5'd7, R3, 1'b0, 2'd0};
        vecs[9]  = '{4'b0000, 4'b0000, 5'd3, 1'b0, 1'b0, 4'b0000, 1'b0, 5'd7, R3, 1'b0, 2'd0};
        vecs[10] = '{4'b0100, 4'b0000, 5'd3, 1'b0, 1'b0, 4'b0100, 1'b1, 5'd9, R2, 1'b0, 2'd0};
        vecs[11] = '{4'b0100, 4'b0000, 5'd3, 1'b0, 1'b0, 4'b0000, 1'b0, 5'd9, R2, 1'b0, 2'd0};
        vecs[12] = '{4'b0100, 4'b0000, 5'd3, 1'b0, 1'b0, 4'b0100, 1'b1, 5'd9, R2, 1'b0, 2'd0};
        vecs[13] = '{4'b0100, 4'b0000, 5'd3, 1'b0, 1'b0, 4'b0000, 1'b0, 5'd9, R2, 1'b0, 2'd0};
        vecs[14] = '{4'b0000, 4'b0000, 5'd3, 1'b0, 1'b0, 4'b0000, 1'b0, 5'd9, R2, 1'b0, 2'd0};
        vecs[15] = '{4'b0001, 4'b0000, 5'd0, 1'b0, 1'b0, 4'b0001, 1'b0, 5'd9, R2, 1'b0, 2'd0};
        vecs[16] = '{4'b1000, 4'b1000, 5'd3, 1'b0, 1'b0, 4'b1000, 1'b0, 5'd9, R2, 1'b1, 2'd3};
        vecs[17] = '{4'b0000, 4'b0000, 5'd3, 1'b0, 1'b0, 4'b0000, 1'b0, 5'd9, R2, 1'b0, 2'd3};
        vecs[18] = '{4'b0010, 4'b0000, 5'd3, 1'b0, 1'b0, 4'b0010, 1'b1, 5'd5, R1, 1'b0, 2'd3};
        vecs[19] = '{4'b0101, 4'b0000, 5'd3, 1'b1, 1'b0, 4'b0000, 1'b0, 5'd5, R1, 1'b0, 2'd3};
        vecs[20] = '{4'b0101, 4'b0000, 5'd3, 1'b1, 1'b0, 4'b0000, 1'b0, 5'd5, R1, 1'b0, 2'd3};
        vecs[21] = '{4'b0101, 4'b0000, 5'd3, 1'b1, 1'b0, 4'b0000, 1'b0, 5'd5, R1, 1'b0, 2'd3};
        vecs[22] = '{4'b0101, 4'b0000, 5'd3, 1'b1, 1'b1, 4'b1111, 1'b0, 5'd5, R1, 1'b0, 2'd3};
        vecs[23] = '{4'b0101, 4'b0000, 5'd3, 1'b0, 1'b0, 4'b0000, 1'b0, 5'd5, R1, 1'b0, 2'd3};
        vecs[24] = '{4'b0101, 4'b0000, 5'd3, 1'b0, 1'b0, 4'b0001, 1'b1, 5'd3, R0, 1'b0, 2'd3};
        vecs[25] = '{4'b0100, 4'b0000, 5'd3, 1'b0, 1'b0, 4'b0100, 1'b1, 5'd9, R2, 1'b0, 2'd3};
        vecs[26] = '{4'b0000, 4'b0000, 5'd3, 1'b0, 1'b0, 4'b0000, 1'b0, 5'd9, R2, 1'b0, 2'd3};

        rst_n    = 1'b0;
        u_valid  = '0;
        u_error  = '0;
        hold     = 1'b0;
        flush    = 1'b0;
        u_res[0] = R0;
        u_res[1] = R1;
        u_res[2] = R2;
        u_res[3] = R3;
        u_rd[0]  = 5'd3;
        u_rd[1]  = 5'd5;
        u_rd[2]  = 5'd9;
        u_rd[3]  = 5'd7;

        #12;
        check_outs("reset", 4'b0000, 1'b0, 5'd0, 32'h0, 1'b0, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            exp_t e;
            @(negedge clk);
            if (sb.size() > 0) check_pop();
            u_valid = vecs[i].valid;
            u_error = vecs[i].err;
            u_rd[0] = vecs[i].rd0;
            hold    = vecs[i].hold;
            flush   = vecs[i].flush;
            e.idx   = i;
            e.clear = vecs[i].e_clear;
            e.we    = vecs[i].e_we;
            e.waddr = vecs[i].e_waddr;
            e.wdata = vecs[i].e_wdata;
            e.errv  = vecs[i].e_errv;
            e.erru  = vecs[i].e_erru;
            sb.push_back(e);
        end
        @(negedge clk);
        check_pop();

        // Reset in the middle of a commit; ptr is 3 here, so unit 3 wins first.
        u_valid = 4'b1010;
        u_rd[0] = 5'd3;
        @(negedge clk);
        check_outs("pre_rst", 4'b1000, 1'b1, 5'd7, R3, 1'b0, 2'd3);
        rst_n = 1'b0;
        #1;
        check_outs("mid_rst", 4'b0000, 1'b0, 5'd0, 32'h0, 1'b0, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_outs("post_rst_g1", 4'b0010, 1'b1, 5'd5, R1, 1'b0, 2'd0);
        u_valid = 4'b1000;
        @(negedge clk);
        check_outs("post_rst_g3", 4'b1000, 1'b1, 5'd7, R3, 1'b0, 2'd0);
        u_valid = 4'b0000;
        @(negedge clk);
        check_outs("post_rst_idle", 4'b0000, 1'b0, 5'd7, R3, 1'b0, 2'd0);

`ifdef COMMIT_ERR_CNT_EN
        chk("err_count_zero", 32'(err_count), 32'h0);
        // Two erroneous units alternate, giving one error commit every cycle.
        u_valid = 4'b0011;
        u_error = 4'b0011;
        repeat (70010) @(negedge clk);
        u_valid = 4'b0000;
        u_error = 4'b0000;
        repeat (4) @(negedge clk);
        chk("err_count_sat", 32'(err_count), 32'h0000_FFFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_commit_unit

// File: doc/commit_unit.md
# commit_unit

Write-back stage of the core: receiver side of the execution-unit commit interface. Collects finished results from N execution units (ALUs), arbitrates one commit per cycle with round-robin fairness, drives the register-file write port, and returns a one-cycle `clear` to the granted unit so it can drop its result. Sits between the ALU bank and the register file.

## Interface
Parameters:
- `N_UNITS`, 4, number of execution units served (2..8).
- `XLEN`, `core_config_pkg::XLEN`, data width.
- `REG_ADDR_W`, `core_config_pkg::REG_ADDR_W`, register index width.

Ports:
- `clk`  in  1  core clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `u_valid`  in  N_UNITS  unit i holds a result.
- `u_res`  in  N_UNITS×XLEN  result of unit i.
- `u_rd`  in  N_UNITS×REG_ADDR_W  destination register of unit i.
- `u_error`  in  N_UNITS  unit i result is erroneous (overflow/illegal).
- `u_clear`  out  N_UNITS  one-hot, one-cycle pulse: unit i result consumed.
- `hold`  in  1  freeze commits (no grant while high).
- `flush`  in  1  discard all pending results.
- `rf_we`  out  1  register-file write enable.
- `rf_waddr`  out  REG_ADDR_W  write address.
- `rf_wdata`  out  XLEN  write data.
- `err_valid`  out  1  one-cycle pulse: committed result was erroneous.
- `err_unit`  out  $clog2(N_UNITS)  source unit of the error.

## Operation
- Eligible unit i: `u_valid[i]=1` and `u_clear[i]=0` (currently asserted clear masks the unit; it needs one cycle to drop valid).
- Round-robin: search from pointer `ptr` upward, wrapping at N_UNITS; first eligible unit g wins. After grant, `ptr <= (g+1) mod N_UNITS`. No grant: `ptr` unchanged.
- Granted, `u_error[g]=0`, `u_rd[g]!=0`: `rf_we=1`, `rf_waddr=u_rd[g]`, `rf_wdata=u_res[g]`.
- Granted, `u_rd[g]==0`: no write (x0), clear still issued.
- Granted, `u_error[g]=1`: no write; `err_valid=1`, `err_unit=g`; clear still issued.
- `u_clear[g]=1` for exactly the cycle the commit outputs are valid.
- `hold=1`: no grant; `rf_we`, `err_valid`, `u_clear` deasserted next cycle; `ptr` kept.
- `flush=1` (priority over `hold` and grant): next cycle `u_clear` = all ones, `rf_we=0`, `err_valid=0`, `ptr <= 0`.
- States: RUN (normal), HELD (`hold` high), FLUSH (one cycle after `flush`, returns to RUN or HELD per `hold`).

## Timing
- Reset values: `u_clear=0`, `rf_we=0`, `rf_waddr=0`, `rf_wdata=0`, `err_valid=0`, `err_unit=0`, `ptr=0`, state RUN.
- Latency: inputs sampled at edge t, commit outputs and `u_clear` registered, valid during cycle t+1. Unit deasserts valid at edge t+2.
- Throughput: one commit per cycle across units; one unit at most every second cycle.
- `rf_waddr`/`rf_wdata` hold previous values when `rf_we=0`.
- Reset mid-commit: all outputs to reset values immediately (async); in-flight commit lost, units keep valid and are re-arbitrated from unit 0 after reset release.
- `hold` and `flush` sampled on the same edge: flush wins.

## Configuration
- `COMMIT_ERR_CNT_EN`: defined adds output `err_count` (16 bit), saturating at 0xFFFF, incremented on every `err_valid` pulse, cleared by reset only. Undefined: port and counter absent, behaviour otherwise identical.

## Test plan
- Single unit: unit 1 valid, rd=5, res=0x0000_00AA -> next cycle rf_we=1, waddr=5, wdata=0xAA, u_clear=0b0010 for one cycle.
- Contention: units 0,1,2,3 all valid from reset (ptr=0), held until cleared -> grants 0,1,2,3 on four consecutive cycles, ptr ends at 0.
- Back-to-back same unit: only unit 2 valid continuously -> grants every other cycle, never two consecutive clears to unit 2.
- x0 and error: unit 0 rd=0 -> no write, clear; unit 3 error=1, rd=7 -> rf_we=0, err_valid=1, err_unit=3, clear=0b1000.
- Hold/flush: hold high 3 cycles with units valid -> no writes; flush -> u_clear=0b1111 one cycle, rf_we=0, next grant starts from unit 0.
- Reset mid-operation: rst_n low during a commit cycle -> all outputs 0 immediately; with `COMMIT_ERR_CNT_EN`, 70000 error commits -> err_count=0xFFFF.
